// File: rtl/serializer_scheduler_if.sv
// Shared bus between the round-robin scheduler and its environment.
// The bus carries the per-channel request words and handshake, and the single
// held word presented to the serializer's parallel-load interface.
//
// Handshake rule for both sides of this bus:
//   A transfer happens on a rising clock edge when valid and ready are both
//   high in that cycle. Valid must not depend on ready. Ready may depend on
//   valid.
//   - Request side: iv_req_valid[k] / ov_req_ready[k], one transfer per grant.
//   - Serializer side: o_ser_din_valid / i_ser_ready, the held word is loaded.
//
// Modports:
//   master - the scheduler: drives grants, the held word, its valid and its tag.
//   slave  - the environment: drives request words/valids and serializer ready.
interface serializer_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int LENGTH = 24
);
  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*LENGTH-1:0] iv_req_data;
  logic [NUM_CH-1:0]        iv_req_valid;
  logic [NUM_CH-1:0]        ov_req_ready;
  logic [LENGTH-1:0]        ov_ser_din;
  logic                     o_ser_din_valid;
  logic                     i_ser_ready;
  logic [CH_BITS-1:0]       ov_ser_ch;

  modport master (
    input  iv_req_data,
    input  iv_req_valid,
    input  i_ser_ready,
    output ov_req_ready,
    output ov_ser_din,
    output o_ser_din_valid,
    output ov_ser_ch
  );

  modport slave (
    output iv_req_data,
    output iv_req_valid,
    output i_ser_ready,
    input  ov_req_ready,
    input  ov_ser_din,
    input  o_ser_din_valid,
    input  ov_ser_ch
  );
endinterface

// File: rtl/serializer_scheduler.sv
// Round-robin scheduler sharing one serializer among NUM_CH word sources.
// A single holding register keeps the granted word and its channel tag and
// presents them to the serializer until it signals ready. A new word can be
// captured in the same cycle the held one is accepted, so back-to-back words
// leave with no bubble.
//
// Ports:
//   i_clk      - clock, all logic on the rising edge
//   i_rst      - synchronous active-high reset, priority over everything
//   i_en       - global enable, low freezes all state and blocks grants/accepts
//   o_idle     - nothing held and no request pending
//   o_dbg_full - FSM state (1 = FULL, 0 = EMPTY)
//   bus        - request and serializer handshakes (master side)
module serializer_scheduler #(
  parameter int NUM_CH = 4,
  parameter int LENGTH = 24
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  output logic                   o_idle,
  output logic                   o_dbg_full,
  serializer_scheduler_if.master bus
);
  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CH_BITS-1:0] ptr_q;
  logic [CH_BITS-1:0] ch_q;
  logic [LENGTH-1:0]  din_q;

  logic [CH_BITS-1:0] grant_idx;
  logic               found;
  logic               acc;
  logic               slot_open;
  logic               grant;
  logic [NUM_CH-1:0]  ready_vec;

  // Round-robin search: start one past the last granted channel and wrap,
  // first valid channel wins. Only valids feed this, never the data.
  always_comb begin
    int c;
    c         = 0;
    found     = 1'b0;
    grant_idx = ptr_q;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = (int'(ptr_q) + i) % NUM_CH;
      if (!found && bus.iv_req_valid[c[CH_BITS-1:0]]) begin
        found     = 1'b1;
        grant_idx = c[CH_BITS-1:0];
      end
    end
  end

  // Next state and grant. The slot opens when empty, or when the held word
  // leaves this cycle, so a refill can overlap the accept.
  always_comb begin
    acc       = 1'b0;
    slot_open = 1'b0;
    grant     = 1'b0;
    ready_vec = '0;
    state_d   = state_q;

    acc       = (state_q == FULL) & bus.i_ser_ready & i_en;
    slot_open = i_en & ~i_rst & ((state_q == EMPTY) | acc);
    grant     = slot_open & found;

    if (grant) begin
      ready_vec[grant_idx] = 1'b1;
    end

    if (grant) begin
      state_d = FULL;
    end else if (acc) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      ptr_q   <= CH_BITS'(NUM_CH - 1);
      din_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        ptr_q <= grant_idx;
        din_q <= bus.iv_req_data[grant_idx*LENGTH +: LENGTH];
        ch_q  <= grant_idx;
      end
    end
  end

  assign bus.ov_req_ready    = ready_vec;
  assign bus.ov_ser_din      = din_q;
  assign bus.ov_ser_ch       = ch_q;
  assign bus.o_ser_din_valid = (state_q == FULL);
  assign o_dbg_full          = (state_q == FULL);
  assign o_idle              = (state_q == EMPTY) & ~|bus.iv_req_valid;
endmodule

// File: tb/tb_serializer_scheduler.sv
// Bench for serializer_scheduler: a driver issues one cycle of stimulus per
// call and predicts the grant with a queue-based reference model; every
// granted word is pushed into exp_q. A monitor on the falling edge compares
// grants, valid, idle and the held word, popping exp_q on each serializer load.
module tb_serializer_scheduler;
  localparam int NUM_CH  = 4;
  localparam int LENGTH  = 24;
  localparam int CH_BITS = $clog2(NUM_CH);
  localparam int W       = CH_BITS + LENGTH;

  // clock / reset
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_en  = 1'b1;
  logic o_idle;
  logic o_dbg_full;
  always #5 i_clk = ~i_clk;

  serializer_scheduler_if #(.NUM_CH(NUM_CH), .LENGTH(LENGTH)) bus ();

  serializer_scheduler #(.NUM_CH(NUM_CH), .LENGTH(LENGTH)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .o_idle     (o_idle),
    .o_dbg_full (o_dbg_full),
    .bus        (bus)
  );

  // scoreboard
  logic [W-1:0]      exp_q[$];
  logic [NUM_CH-1:0] exp_ready;
  logic              exp_valid;
  logic              exp_idle;
  logic              exp_post_rst;
  int                n_tests = 0;
  int                n_fail  = 0;
  bit                mon_en  = 1'b0;

  // reference model state
  bit m_full  = 1'b0;
  int m_ptr   = NUM_CH - 1;
  bit m_clear = 1'b0;
  bit prev_rst = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH*LENGTH-1:0] rand_data();
    logic [NUM_CH*LENGTH-1:0] d;
    for (int k = 0; k < NUM_CH; k++) d[k*LENGTH +: LENGTH] = LENGTH'($urandom);
    return d;
  endfunction

  // driver: one cycle of stimulus plus the model's prediction for it
  task automatic step(input bit rst, input bit en, input logic [NUM_CH-1:0] valid,
                      input bit ready, input logic [NUM_CH*LENGTH-1:0] data);
    int g;
    bit acc;
    bit open;
    @(posedge i_clk);
    #1;
    if (m_clear) begin
      exp_q.delete();
      m_clear = 1'b0;
    end
    exp_post_rst = prev_rst;
    prev_rst     = rst;

    i_rst            = rst;
    i_en             = en;
    bus.iv_req_valid = valid;
    bus.iv_req_data  = data;
    bus.i_ser_ready  = ready;

    exp_valid = m_full;
    exp_idle  = !m_full && (valid == '0);
    exp_ready = '0;
    if (rst) begin
      m_full  = 1'b0;
      m_ptr   = NUM_CH - 1;
      m_clear = 1'b1;
    end else begin
      acc  = m_full && ready && en;
      open = en && (!m_full || acc);
      g    = -1;
      if (open) begin
        for (int k = 1; k <= NUM_CH; k++) begin
          int c;
          c = (m_ptr + k) % NUM_CH;
          if (g < 0 && valid[c]) g = c;
        end
      end
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
        exp_q.push_back({CH_BITS'(g), data[g*LENGTH +: LENGTH]});
        m_full = 1'b1;
        m_ptr  = g;
      end else if (acc) begin
        m_full = 1'b0;
      end
    end
    mon_en = 1'b1;
  endtask

  // monitor: sample mid-cycle, well away from the rising edge
  initial begin
    forever begin
      @(negedge i_clk);
      if (mon_en) begin
        chk("req_ready", 64'(bus.ov_req_ready), 64'(exp_ready));
        chk("din_valid", 64'(bus.o_ser_din_valid), 64'(exp_valid));
        chk("dbg_full", 64'(o_dbg_full), 64'(exp_valid));
        chk("idle", 64'(o_idle), 64'(exp_idle));
        if (exp_post_rst) begin
          chk("rst_din", 64'(bus.ov_ser_din), 64'(0));
          chk("rst_ch", 64'(bus.ov_ser_ch), 64'(0));
        end
        if (bus.o_ser_din_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL held_word: valid word %0h with nothing expected at %0t",
                     bus.ov_ser_din, $time);
          end else begin
            chk("held_din", 64'(bus.ov_ser_din), 64'(exp_q[0][LENGTH-1:0]));
            chk("held_ch", 64'(bus.ov_ser_ch), 64'(exp_q[0][W-1:LENGTH]));
            if (bus.i_ser_ready && i_en && !i_rst) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [NUM_CH*LENGTH-1:0] d;
    bus.iv_req_valid = '1;
    bus.iv_req_data  = '0;
    bus.i_ser_ready  = 1'b0;

    // reset with all requests valid, then first grant goes to ch0
    step(1, 1, 4'b1111, 0, rand_data());
    step(1, 1, 4'b1111, 0, rand_data());
    step(0, 1, 4'b1111, 0, rand_data());
    step(0, 1, 4'b0000, 1, rand_data());
    step(0, 1, 4'b0000, 0, rand_data());

    // single request on ch2
    d = rand_data();
    d[2*LENGTH +: LENGTH] = 24'hABCDEF;
    step(0, 1, 4'b0100, 0, d);
    step(0, 1, 4'b0000, 0, rand_data());
    step(0, 1, 4'b0000, 1, rand_data());

    // round-robin, one word per cycle
    for (int i = 0; i < 8; i++) step(0, 1, 4'b1111, 1, rand_data());

    // backpressure then a single ready pulse
    for (int i = 0; i < 10; i++) step(0, 1, 4'b1111, 0, rand_data());
    step(0, 1, 4'b1111, 1, rand_data());

    // enable low while full and ready, then re-enable
    for (int i = 0; i < 3; i++) step(0, 0, 4'b1111, 1, rand_data());
    step(0, 1, 4'b0000, 1, rand_data());

    // reset mid-operation
    step(0, 1, 4'b0010, 0, rand_data());
    step(1, 1, 4'b0010, 0, rand_data());
    step(0, 1, 4'b0011, 0, rand_data());
    step(0, 1, 4'b0011, 1, rand_data());
    step(0, 1, 4'b0000, 1, rand_data());

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
           NUM_CH'($urandom), ($urandom_range(0, 2) != 0), rand_data());
    end

    // drain
    for (int i = 0; i < 4; i++) step(0, 1, 4'b0000, 1, rand_data());

    @(negedge i_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
